// File: rtl/core_config_pkg.sv
// Shared core configuration: bus width, machine-timer register map and byte-lane merge helper.
// Pure declarations; no latency or flow control of its own.
package core_config_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] MTIMER_BASE = 32'h0002_0000;

  typedef enum logic [2:0] {
    MT_CTRL        = 3'd0,
    MT_PRESCALE    = 3'd1,
    MT_MTIME_LO    = 3'd2,
    MT_MTIME_HI    = 3'd3,
    MT_MTIMECMP_LO = 3'd4,
    MT_MTIMECMP_HI = 3'd5,
    MT_STATUS      = 3'd6,
    MT_RSVD        = 3'd7
  } mtimer_reg_e;

  localparam int CTRL_CNT_EN = 0;
  localparam int CTRL_IRQ_EN = 1;

  function automatic logic [XLEN-1:0] merge_bytes(input logic [XLEN-1:0] cur,
                                                  input logic [XLEN-1:0] wdata,
                                                  input logic [XLEN/8-1:0] be);
    logic [XLEN-1:0] r;
    r = cur;
    for (int i = 0; i < XLEN/8; i++) begin
      if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Prescaler for mtime: pcnt counts 0..reload while en, tick is combinational on the terminal count.
// Latency: tick in the same cycle pcnt==reload; clr wins over counting; no backpressure.
module mtimer_prescaler #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] reload,
  input  logic         clr,
  output logic         tick
);

  logic [W-1:0] pcnt;

  assign tick = en & (pcnt == reload);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (clr || tick) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/mtimer_responder.sv
// Memory-mapped machine timer (mtime/mtimecmp/prescaler) with a level timer interrupt.
// Latency: one cycle registered response per selected access; accepts every cycle, never stalls.
module mtimer_responder #(
  parameter int              XLEN       = core_config_pkg::XLEN,
  parameter logic [XLEN-1:0] BASE_ADDR  = core_config_pkg::MTIMER_BASE,
  parameter int              PRESCALE_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [XLEN/8-1:0] mem_byteen,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN-1:0]   mem_rdata,
  output logic              resp_valid,
  output logic              mem_err,
  output logic              timer_irq
);
  import core_config_pkg::*;

  mtimer_reg_e           off;
  logic                  sel, wr, rd;
  logic [1:0]            ctrl;
  logic [PRESCALE_W-1:0] prescale;
  logic [63:0]           mtime, mtimecmp;
  logic [31:0]           hi_shadow;
  logic                  tick, cmp_hit;
  logic [XLEN-1:0]       rdata_c, cur_c, wmerge;
  logic                  err_c;
  logic                  unused_ok;

  assign sel     = mem_req & (mem_addr[XLEN-1:5] == BASE_ADDR[XLEN-1:5]);
  assign off     = mtimer_reg_e'(mem_addr[4:2]);
  assign wr      = sel & mem_we;
  assign rd      = sel & ~mem_we;
  assign cmp_hit = mtime >= mtimecmp;
  assign unused_ok = &{1'b0, mem_addr[1:0]};

  // cur_c differs from rdata_c only for MTIME_HI: reads see the shadow, writes merge into the live half.
  always_comb begin
    rdata_c = '0;
    cur_c   = '0;
    err_c   = 1'b0;
    case (off)
      MT_CTRL:        rdata_c = XLEN'(ctrl);
      MT_PRESCALE:    rdata_c = XLEN'(prescale);
      MT_MTIME_LO:    rdata_c = mtime[31:0];
      MT_MTIME_HI:    rdata_c = hi_shadow;
      MT_MTIMECMP_LO: rdata_c = mtimecmp[31:0];
      MT_MTIMECMP_HI: rdata_c = mtimecmp[63:32];
      MT_STATUS: begin
        rdata_c = XLEN'(cmp_hit);
        err_c   = mem_we;
      end
      default:        err_c   = 1'b1;
    endcase
    cur_c = (off == MT_MTIME_HI) ? mtime[63:32] : rdata_c;
  end

  assign wmerge = merge_bytes(cur_c, mem_wdata, mem_byteen);

  mtimer_prescaler #(.W(PRESCALE_W)) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (ctrl[CTRL_CNT_EN]),
    .reload (prescale),
    .clr    (wr && (off == MT_PRESCALE)),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl     <= '0;
      prescale <= '0;
      mtimecmp <= '1;
    end else if (wr) begin
      case (off)
        MT_CTRL:        ctrl            <= wmerge[1:0];
        MT_PRESCALE:    prescale        <= wmerge[PRESCALE_W-1:0];
        MT_MTIMECMP_LO: mtimecmp[31:0]  <= wmerge;
        MT_MTIMECMP_HI: mtimecmp[63:32] <= wmerge;
        default: ;
      endcase
    end
  end

  // A software write to either half suppresses the increment for the whole counter that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime <= '0;
    end else if (wr && (off == MT_MTIME_LO)) begin
      mtime[31:0] <= wmerge;
    end else if (wr && (off == MT_MTIME_HI)) begin
      mtime[63:32] <= wmerge;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_shadow  <= '0;
      resp_valid <= 1'b0;
      mem_rdata  <= '0;
      mem_err    <= 1'b0;
      timer_irq  <= 1'b0;
    end else begin
      if (rd && (off == MT_MTIME_LO)) hi_shadow <= mtime[63:32];
      resp_valid <= sel;
      mem_rdata  <= rd ? rdata_c : '0;
      mem_err    <= sel & err_c;
      timer_irq  <= ctrl[CTRL_IRQ_EN] & cmp_hit;
    end
  end

endmodule
